tlb_refill_unit: RTL and testbench

- Hardware miss handler that sits on the other end of the TLB's refill write port.
- On a TLB miss it reads one page-table entry (PTE) from memory through a simple request/ready read port.
- It then either writes the translation into the TLB as a one-cycle write pulse, or raises a page fault.
- It stalls the pipeline for the whole walk. Single-level page table; base address comes from ptbr_i.

---
 rtl/tlb_refill_unit_pkg.sv | 31 +++
 rtl/tlb_refill_unit_pte_decoder.sv | 18 +
 rtl/tlb_refill_unit.sv | 153 +++++++++++++++
 tb/tb_tlb_refill_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_refill_unit_pkg.sv
// Shared TLB refill definitions: page geometry macros, PTE field layout and walker state encodings.
`ifndef OFFSET
`define OFFSET 12
`endif
`ifndef PHYS_ADDR_SIZE
`define PHYS_ADDR_SIZE 20
`endif

package tlb_refill_unit_pkg;

   localparam int unsigned OFFSET         = `OFFSET;
   localparam int unsigned PHYS_ADDR_SIZE = `PHYS_ADDR_SIZE;
   localparam int unsigned VPN_W          = 32 - OFFSET;
   localparam int unsigned PPN_W          = PHYS_ADDR_SIZE - OFFSET;

   localparam int unsigned PTE_VALID_BIT  = 0;
   localparam int unsigned PTE_PPN_LSB    = OFFSET;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_FAULT  = 3'd3;
   localparam logic [2:0] ST_SETTLE = 3'd4;

   // Payload presented on the TLB refill write port.
   typedef struct packed {
      logic [VPN_W-1:0] vpn;
      logic [VPN_W-1:0] ppn;
   } tlb_refill_t;

endpackage

// File: rtl/tlb_refill_unit_pte_decoder.sv
// Combinational PTE field extraction: valid flag and zero-extended physical page number.
module tlb_refill_unit_pte_decoder
   import tlb_refill_unit_pkg::*;
(
   input  logic [31:0]      i_pte,
   output logic             o_pte_valid,
   output logic [VPN_W-1:0] o_phys_page
);

   logic [PPN_W-1:0] w_ppn;
   logic             w_unused_bits;

   assign o_pte_valid   = i_pte[PTE_VALID_BIT];
   assign w_ppn         = i_pte[PTE_PPN_LSB +: PPN_W];
   assign o_phys_page   = VPN_W'(w_ppn);
   assign w_unused_bits = ^{i_pte[31:PHYS_ADDR_SIZE], i_pte[PTE_PPN_LSB-1:PTE_VALID_BIT+1]};

endmodule

// File: rtl/tlb_refill_unit.sv
// Single-level TLB miss handler: fetches one PTE, then refills the TLB or raises a page fault.
// Optional memory-wait timeout enabled by defining TLB_REFILL_TIMEOUT_EN.
module tlb_refill_unit
   import tlb_refill_unit_pkg::*;
#(
   parameter int unsigned PTE_BYTES      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tlb_miss_i,
   input  logic [31:0]      miss_virtual_address_i,
   input  logic [31:0]      ptbr_i,
   output logic             mem_req_o,
   output logic [31:0]      mem_addr_o,
   input  logic             mem_ready_i,
   input  logic [31:0]      mem_data_i,
   output logic [VPN_W-1:0] w_virtual_page_o,
   output logic [VPN_W-1:0] w_phys_page_o,
   output logic             write_enable_o,
   output logic             stall_o,
   output logic             page_fault_o,
   output logic [VPN_W-1:0] fault_vpn_o
);

   logic [2:0]       r_state, w_state_nxt;
   logic [VPN_W-1:0] r_vpn, w_vpn_nxt;
   logic             r_mem_req, w_mem_req_nxt;
   logic [31:0]      r_mem_addr, w_mem_addr_nxt;
   logic             r_we, w_we_nxt;
   logic             r_pf, w_pf_nxt;
   tlb_refill_t      r_wr, w_wr_nxt;
   logic [VPN_W-1:0] r_fault_vpn, w_fault_vpn_nxt;

   logic             w_pte_valid;
   logic [VPN_W-1:0] w_ppn;
   logic [VPN_W-1:0] w_va_vpn;
   logic [31:0]      w_pte_addr;
   logic             w_unused_bits;

`ifdef TLB_REFILL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

   tlb_refill_unit_pte_decoder u_pte_decoder (
      .i_pte       (mem_data_i),
      .o_pte_valid (w_pte_valid),
      .o_phys_page (w_ppn)
   );

   assign w_va_vpn      = miss_virtual_address_i[31:OFFSET];
   assign w_pte_addr    = ptbr_i + 32'(w_va_vpn) * 32'(PTE_BYTES);
   assign w_unused_bits = ^{miss_virtual_address_i[OFFSET-1:0], 32'(TIMEOUT_CYCLES)};

   // Stall covers the miss cycle itself; the fault cycle releases the pipeline.
   assign stall_o = (r_state == ST_IDLE) ? tlb_miss_i : (r_state != ST_FAULT);

   assign mem_req_o        = r_mem_req;
   assign mem_addr_o       = r_mem_addr;
   assign write_enable_o   = r_we;
   assign page_fault_o     = r_pf;
   assign w_virtual_page_o = r_wr.vpn;
   assign w_phys_page_o    = r_wr.ppn;
   assign fault_vpn_o      = r_fault_vpn;

   always_comb begin
      w_state_nxt     = r_state;
      w_vpn_nxt       = r_vpn;
      w_mem_req_nxt   = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_we_nxt        = 1'b0;
      w_pf_nxt        = 1'b0;
      w_wr_nxt        = r_wr;
      w_fault_vpn_nxt = r_fault_vpn;
`ifdef TLB_REFILL_TIMEOUT_EN
      w_cnt_nxt       = r_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (tlb_miss_i) begin
               w_vpn_nxt      = w_va_vpn;
               w_mem_addr_nxt = w_pte_addr;
               w_mem_req_nxt  = 1'b1;
               w_state_nxt    = ST_REQ;
`ifdef TLB_REFILL_TIMEOUT_EN
               w_cnt_nxt      = '0;
`endif
            end
         end
         ST_REQ: begin
            w_mem_req_nxt = 1'b1;
            if (mem_ready_i) begin
               w_mem_req_nxt = 1'b0;
               if (w_pte_valid) begin
                  w_we_nxt     = 1'b1;
                  w_wr_nxt.vpn = r_vpn;
                  w_wr_nxt.ppn = w_ppn;
                  w_state_nxt  = ST_WRITE;
               end else begin
                  w_pf_nxt        = 1'b1;
                  w_fault_vpn_nxt = r_vpn;
                  w_state_nxt     = ST_FAULT;
               end
            end
`ifdef TLB_REFILL_TIMEOUT_EN
            // A response arriving on the final wait cycle takes priority over the timeout.
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_mem_req_nxt   = 1'b0;
               w_pf_nxt        = 1'b1;
               w_fault_vpn_nxt = r_vpn;
               w_state_nxt     = ST_FAULT;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
         end
         ST_WRITE:  w_state_nxt = ST_SETTLE;
         ST_FAULT:  w_state_nxt = ST_IDLE;
         ST_SETTLE: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_vpn       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_we        <= 1'b0;
         r_pf        <= 1'b0;
         r_wr        <= '0;
         r_fault_vpn <= '0;
`ifdef TLB_REFILL_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_vpn       <= w_vpn_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_we        <= w_we_nxt;
         r_pf        <= w_pf_nxt;
         r_wr        <= w_wr_nxt;
         r_fault_vpn <= w_fault_vpn_nxt;
`ifdef TLB_REFILL_TIMEOUT_EN
         r_cnt       <= w_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_tlb_refill_unit.sv
// Bench for tlb_refill_unit: directed walks with literal expectations plus randomized traffic
// checked every cycle against a walk-level reference model (timeout cases when TLB_REFILL_TIMEOUT_EN is set).
module tb_tlb_refill_unit;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tlb_miss_i = 1'b0;
   logic [31:0] va = '0;
   logic [31:0] ptbr = '0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_data = '0;

   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [19:0] wvp, wpp, fvpn;
   logic        we, stall, pf;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state: walk-level bookkeeping, not a copy of the DUT encoding.
   bit          m_idle = 1'b1;
   int          m_wait = 0;
   int          m_tail = 0;
   logic [19:0] m_vpn = '0;
   logic        e_req = 1'b0, e_we = 1'b0, e_pf = 1'b0;
   logic [31:0] e_addr = '0;
   logic [19:0] e_wvp = '0, e_wpp = '0, e_fvpn = '0;

   tlb_refill_unit #(.PTE_BYTES(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .tlb_miss_i             (tlb_miss_i),
      .miss_virtual_address_i (va),
      .ptbr_i                 (ptbr),
      .mem_req_o              (mem_req_o),
      .mem_addr_o             (mem_addr_o),
      .mem_ready_i            (mem_ready),
      .mem_data_i             (mem_data),
      .w_virtual_page_o       (wvp),
      .w_phys_page_o          (wpp),
      .write_enable_o         (we),
      .stall_o                (stall),
      .page_fault_o           (pf),
      .fault_vpn_o            (fvpn)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: on each edge decide what the walk does, from the behavioural rules.
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_idle = 1'b1; m_wait = 0; m_tail = 0; m_vpn = '0;
         e_req = 1'b0; e_we = 1'b0; e_pf = 1'b0; e_addr = '0;
         e_wvp = '0; e_wpp = '0; e_fvpn = '0;
      end else begin
         e_we = 1'b0;
         e_pf = 1'b0;
         if (m_idle) begin
            if (tlb_miss_i) begin
               m_vpn  = 20'(va >> 12);
               e_addr = ptbr + (va >> 12) * 32'd4;
               e_req  = 1'b1;
               m_idle = 1'b0;
               m_wait = 0;
            end
         end else if (e_req) begin
            if (mem_ready) begin
               e_req = 1'b0;
               if (mem_data[0]) begin
                  e_we = 1'b1; e_wvp = m_vpn; e_wpp = 20'((mem_data >> 12) & 32'hFF);
                  m_tail = 2;
               end else begin
                  e_pf = 1'b1; e_fvpn = m_vpn;
                  m_tail = 1;
               end
            end else begin
               m_wait++;
`ifdef TLB_REFILL_TIMEOUT_EN
               if (m_wait == TO) begin
                  e_req = 1'b0; e_pf = 1'b1; e_fvpn = m_vpn;
                  m_tail = 1;
               end
`endif
            end
         end else begin
            m_tail--;
            if (m_tail == 0) m_idle = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      #2;
      forever begin
         @(negedge clk);
         check("mem_req",  32'(mem_req_o), 32'(e_req));
         check("mem_addr", mem_addr_o,     e_addr);
         check("we",       32'(we),        32'(e_we));
         check("pf",       32'(pf),        32'(e_pf));
         check("wvp",      32'(wvp),       32'(e_wvp));
         check("wpp",      32'(wpp),       32'(e_wpp));
         check("fvpn",     32'(fvpn),      32'(e_fvpn));
         check("stall",    32'(stall),     32'(m_idle ? tlb_miss_i : !e_pf));
      end
   end

   // Starts a walk, serves the PTE after 'wait_n' request cycles; returns in the WRITE/FAULT cycle.
   task automatic walk(input logic [31:0] p, input logic [31:0] v, input int wait_n,
                       input logic [31:0] d, input logic [31:0] exp_addr, input bit early_ready);
      ptbr = p; va = v; tlb_miss_i = 1'b1;
      mem_ready = early_ready; mem_data = 32'h0;
      #1;
      check("stall_on_miss", 32'(stall), 32'd1);
      tick();
      tlb_miss_i = 1'b0; mem_ready = 1'b0;
      check("walk_addr", mem_addr_o, exp_addr);
      check("walk_req", 32'(mem_req_o), 32'd1);
      repeat (wait_n - 1) tick();
      mem_ready = 1'b1; mem_data = d;
      tick();
      mem_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      #1 reset = 1'b1;
      tick(); tick();
      check("rst_req",   32'(mem_req_o), 32'd0);
      check("rst_stall", 32'(stall),     32'd0);
      check("rst_addr",  mem_addr_o,     32'd0);
      check("rst_fvpn",  32'(fvpn),      32'd0);
      reset = 1'b0;
      tick();

      // Valid refill
      walk(32'h0001_0000, 32'h0000_5ABC, 3, 32'h0003_7001, 32'h0001_0014, 1'b0);
      check("valid_we",    32'(we),    32'd1);
      check("valid_wvp",   32'(wvp),   32'h5);
      check("valid_wpp",   32'(wpp),   32'h37);
      check("valid_stall", 32'(stall), 32'd1);
      check("valid_pf",    32'(pf),    32'd0);
      tick();
      check("settle_we",    32'(we),    32'd0);
      check("settle_stall", 32'(stall), 32'd1);
      tick();
      check("idle_stall", 32'(stall), 32'd0);

      // Invalid PTE
      walk(32'h0001_0000, 32'h0000_5ABC, 3, 32'h0003_7000, 32'h0001_0014, 1'b0);
      check("inv_pf",    32'(pf),    32'd1);
      check("inv_fvpn",  32'(fvpn),  32'h5);
      check("inv_we",    32'(we),    32'd0);
      check("inv_stall", 32'(stall), 32'd0);
      tick();
      check("inv_pf_pulse", 32'(pf), 32'd0);

      // Address wrap, with a ready during the miss cycle that must be ignored
      walk(32'hFFFF_FFF0, 32'h0000_8000, 1, 32'h0001_2341, 32'h0000_0010, 1'b1);
      check("wrap_we",  32'(we),  32'd1);
      check("wrap_wvp", 32'(wvp), 32'h8);
      check("wrap_wpp", 32'(wpp), 32'h12);
      tick(); tick();

      // Back-to-back misses: miss held through SETTLE with a new VA
      walk(32'h0001_0000, 32'h0000_5ABC, 2, 32'h0003_7001, 32'h0001_0014, 1'b0);
      tlb_miss_i = 1'b1; va = 32'h0000_9000;
      tick();
      check("b2b_settle_stall", 32'(stall), 32'd1);
      tick();
      check("b2b_idle_stall", 32'(stall), 32'd1);
      tick();
      tlb_miss_i = 1'b0;
      check("b2b_addr", mem_addr_o, 32'h0001_0024);
      mem_ready = 1'b1; mem_data = 32'h0004_5001;
      tick();
      mem_ready = 1'b0;
      check("b2b_we",  32'(we),  32'd1);
      check("b2b_wvp", 32'(wvp), 32'h9);
      check("b2b_wpp", 32'(wpp), 32'h45);
      tick();
      check("b2b_single_pulse", 32'(we), 32'd0);
      tick();

      // Mid-walk reset
      ptbr = 32'h0001_0000; va = 32'h0000_3000; tlb_miss_i = 1'b1;
      tick();
      tlb_miss_i = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      check("mrst_req",   32'(mem_req_o), 32'd0);
      check("mrst_stall", 32'(stall),     32'd0);
      check("mrst_addr",  mem_addr_o,     32'd0);
      check("mrst_fvpn",  32'(fvpn),      32'd0);
      check("mrst_wvp",   32'(wvp),       32'd0);
      tick();
      reset = 1'b0; mem_ready = 1'b1; mem_data = 32'h0000_1001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("late_ready_we", 32'(we), 32'd0);
         check("late_ready_pf", 32'(pf), 32'd0);
      end
      mem_ready = 1'b0; mem_data = '0;
      tick();

`ifdef TLB_REFILL_TIMEOUT_EN
      ptbr = 32'h0000_2000; va = 32'h0000_7000; tlb_miss_i = 1'b1;
      tick();
      tlb_miss_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20 && mem_req_o; i++) begin
         cnt++;
         tick();
      end
      check("to_req_cycles", 32'(cnt),       32'd8);
      check("to_pf",         32'(pf),        32'd1);
      check("to_fvpn",       32'(fvpn),      32'h7);
      check("to_req_low",    32'(mem_req_o), 32'd0);
      tick();
      check("to_req_after",  32'(mem_req_o), 32'd0);
      tick();
`else
      cnt = 0;
`endif

      // Randomized traffic checked by the model
      for (int i = 0; i < 600; i++) begin
         tlb_miss_i = ($urandom % 4) == 0;
         va         = $urandom;
         ptbr       = $urandom;
         mem_ready  = ($urandom % 3) == 0;
         mem_data   = $urandom;
         tick();
      end
      tlb_miss_i = 1'b0; mem_ready = 1'b1; mem_data = 32'h0000_0001;
      repeat (4) tick();
      mem_ready = 1'b0;
      repeat (4) tick();
      check("final_stall", 32'(stall), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
